// File: rtl/avalon_ram_slave.sv
// avalon_ram_slave: Avalon-MM RAM responder with programmable wait states and sticky bus-error flag
module avalon_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          WAIT_CYCLES = 0,
  parameter bit          RANDOM_WAIT = 1'b0,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] address,
  input  logic        write,
  input  logic        read,
  output logic        waitrequest,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  output logic [31:0] readdata,
  output logic        bus_error
);
  localparam int AW = $clog2(DEPTH_WORDS);
  typedef enum logic [1:0] {IDLE, WAIT, ACCEPT} state_t;
  state_t state, state_nxt;
  logic [3:0] cnt, cnt_nxt, target, target_q, lfsr;
  logic [31:0] mem [DEPTH_WORDS];
  logic [29:0] word_off;
  logic [AW-1:0] idx;
  logic req, accept, illegal;
  assign req = read | write;
  assign word_off = 30'((address - BASE_ADDR) >> 2);
  assign idx = word_off[AW-1:0];
  assign illegal = (|address[1:0]) || (word_off >= 30'(DEPTH_WORDS)) || (read && write);
  assign target = (state == IDLE)
    ? (RANDOM_WAIT ? 4'({1'b0, lfsr} % 5'(WAIT_CYCLES + 1)) : 4'(WAIT_CYCLES))
    : target_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  always_comb begin
    state_nxt = (!req || accept) ? IDLE : ((cnt + 4'd1 == target) ? ACCEPT : WAIT);
    cnt_nxt = (!req || accept) ? '0 : cnt + 4'd1;
  end
  always_comb begin
    waitrequest = req && (cnt != target);
    accept = req && !waitrequest;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      target_q <= '0;
      lfsr <= 4'b1001;
      readdata <= '0;
      bus_error <= 1'b0;
    end else begin
      if (state == IDLE) target_q <= target;
      if (accept) lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
      if (accept && read) readdata <= illegal ? '0 : mem[idx];
      bus_error <= bus_error | (accept & illegal);
    end
  always_ff @(posedge clk)
    if (accept && write && !illegal)
      for (int i = 0; i < 4; i++)
        if (byteenable[i]) mem[idx][8*i +: 8] <= writedata[8*i +: 8];
endmodule

// File: tb/tb_avalon_ram_slave.sv
// tb_avalon_ram_slave: random and directed checks of three RAM instances (0 waits, 3 waits, random 0..7 waits)
module tb_avalon_ram_slave;
  localparam logic [31:0] BASE = 32'hBFC00000;
  localparam int DEPTH = 4096;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] address [3];
  logic [31:0] writedata [3];
  logic [31:0] readdata [3];
  logic [3:0] byteenable [3];
  logic read [3];
  logic write [3];
  logic waitrequest [3];
  logic bus_error [3];
  int checks = 0;
  int errors = 0;
  logic [31:0] ref_mem [64];
  always #5 clk = ~clk;
  avalon_ram_slave #(.WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .address(address[0]), .write(write[0]), .read(read[0]),
    .waitrequest(waitrequest[0]), .writedata(writedata[0]), .byteenable(byteenable[0]),
    .readdata(readdata[0]), .bus_error(bus_error[0]));
  avalon_ram_slave #(.WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .address(address[1]), .write(write[1]), .read(read[1]),
    .waitrequest(waitrequest[1]), .writedata(writedata[1]), .byteenable(byteenable[1]),
    .readdata(readdata[1]), .bus_error(bus_error[1]));
  avalon_ram_slave #(.WAIT_CYCLES(7), .RANDOM_WAIT(1'b1)) u_rnd (
    .clk(clk), .reset(reset), .address(address[2]), .write(write[2]), .read(read[2]),
    .waitrequest(waitrequest[2]), .writedata(writedata[2]), .byteenable(byteenable[2]),
    .readdata(readdata[2]), .bus_error(bus_error[2]));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  // Called at a negedge; returns at the negedge after acceptance with the request dropped
  task automatic xfer(input int d, input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be, output int waits);
    read[d] = rd;
    write[d] = wr;
    address[d] = a;
    writedata[d] = wd;
    byteenable[d] = be;
    waits = 0;
    #1;
    while (waitrequest[d]) begin
      waits++;
      if (waits > 40) begin
        chk("wait_timeout", waits, 0);
        break;
      end
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    @(negedge clk);
    read[d] = 1'b0;
    write[d] = 1'b0;
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int wt, w;
    logic [31:0] a, wd, rel, exp;
    logic [3:0] be;
    logic rd, wr, ill, ebus;
    logic [15:0] seen;
    for (int d = 0; d < 3; d++) begin
      read[d] = 1'b0;
      write[d] = 1'b0;
      address[d] = '0;
      writedata[d] = '0;
      byteenable[d] = '0;
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int d = 0; d < 3; d++) begin
      chk("rst_rdata", readdata[d], 0);
      chk("rst_buserr", 32'(bus_error[d]), 0);
      chk("rst_wreq", 32'(waitrequest[d]), 0);
    end
    xfer(0, 0, 1, BASE, 32'h24020005, 4'hF, wt);
    chk("w0_write_wait", wt, 0);
    xfer(0, 1, 0, BASE, 0, 4'h0, wt);
    chk("w0_read_wait", wt, 0);
    chk("w0_rdata", readdata[0], 32'h24020005);
    chk("w0_buserr", 32'(bus_error[0]), 0);
    xfer(1, 0, 1, BASE, 32'h11111111, 4'hF, wt);
    xfer(1, 0, 1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, wt);
    chk("w3_write_wait", wt, 3);
    xfer(1, 1, 0, BASE + 32'h10, 0, 4'h0, wt);
    chk("w3_read_wait", wt, 3);
    chk("w3_rdata", readdata[1], 32'hDEADBEEF);
    xfer(1, 0, 1, BASE + 32'h10, 32'h0000AA00, 4'b0010, wt);
    xfer(1, 0, 1, BASE + 32'h10, 32'h12345678, 4'b0000, wt);
    xfer(1, 1, 0, BASE + 32'h10, 0, 4'h0, wt);
    chk("lane_merge", readdata[1], 32'hDEADAAEF);
    xfer(1, 1, 0, 32'h0, 0, 4'h0, wt);
    chk("below_base_rdata", readdata[1], 0);
    chk("below_base_buserr", 32'(bus_error[1]), 1);
    xfer(1, 0, 1, BASE + 32'h2, 32'hFFFFFFFF, 4'hF, wt);
    xfer(1, 1, 1, BASE + 32'h10, 32'hFFFFFFFF, 4'hF, wt);
    chk("rdwr_rdata", readdata[1], 0);
    xfer(1, 1, 0, BASE, 0, 4'h0, wt);
    chk("misalign_intact", readdata[1], 32'h11111111);
    chk("sticky_buserr", 32'(bus_error[1]), 1);
    xfer(1, 1, 0, BASE + 32'h10, 0, 4'h0, wt);
    chk("rdwr_intact", readdata[1], 32'hDEADAAEF);
    reset = 1'b1;
    #1;
    chk("async_clr_buserr", 32'(bus_error[1]), 0);
    @(negedge clk);
    reset = 1'b0;
    xfer(1, 1, 0, BASE + 32'h10, 0, 4'h0, wt);
    chk("post_rst_rdata", readdata[1], 32'hDEADAAEF);
    read[1] = 1'b1;
    address[1] = BASE;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_rst_rdata", readdata[1], 0);
    chk("mid_rst_wreq", 32'(waitrequest[1]), 1);
    @(negedge clk);
    reset = 1'b0;
    xfer(1, 1, 0, BASE, 0, 4'h0, wt);
    chk("reissue_wait", wt, 3);
    chk("reissue_rdata", readdata[1], 32'h11111111);
    for (int i = 0; i < 64; i++) begin
      ref_mem[i] = $urandom;
      xfer(2, 0, 1, BASE + 32'(4 * i), ref_mem[i], 4'hF, wt);
    end
    ebus = 1'b0;
    seen = '0;
    for (int n = 0; n < 200; n++) begin
      w = $urandom_range(0, 99);
      a = BASE + 32'(4 * $urandom_range(0, 63));
      if (w < 5) a = a + 32'($urandom_range(1, 3));
      else if (w < 10) a = BASE + 32'(4 * (DEPTH + $urandom_range(0, 100)));
      else if (w < 13) a = $urandom_range(0, 32'hBFBFFFFF);
      w = $urandom_range(0, 9);
      rd = (w == 0) || (w < 5);
      wr = (w == 0) || (w >= 5);
      wd = $urandom;
      be = 4'($urandom);
      rel = a - BASE;
      ill = (a % 4 != 0) || (rel / 4 >= DEPTH) || (rd && wr);
      xfer(2, rd, wr, a, wd, be, wt);
      ebus = ebus | ill;
      w = int'(rel / 4);
      if (wr && !ill)
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
      if (rd) begin
        exp = ill ? 32'h0 : ref_mem[w];
        chk("rnd_rdata", readdata[2], exp);
      end
      chk("rnd_buserr", 32'(bus_error[2]), 32'(ebus));
      chk("rnd_wait_range", 32'(wt <= 7), 1);
      if (wt < 16) seen[wt] = 1'b1;
    end
    chk("rnd_wait_variety", 32'($countones(seen) > 1), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
